// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: MEM stage controller sitting between the EX/MEM register and
// the data memory. It takes one request at a time, drives the memory port
// (MAR/MDR/mem/rw/en), owns the stack pointer, and returns a one-cycle
// out_valid pulse to MEM/WB.
// Optional feature macro: STACK_BOUNDS_CHECK_EN. When it is defined, a PUSH
// into a full stack or a POP from an empty stack is suppressed and reported
// on stack_exc.
module mem_stage_ctrl #(
    parameter int WORD_LENGTH   = 16,
    parameter int ADDRESS_SPACE = 12,
    parameter int SP_RESET      = 2**ADDRESS_SPACE - 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2:0]               in_op,
    input  logic [ADDRESS_SPACE-1:0] in_addr,
    input  logic [WORD_LENGTH-1:0]   in_wdata,
    input  logic [2:0]               in_rdst,
    input  logic                     in_wb,
    output logic [ADDRESS_SPACE-1:0] MAR,
    inout  wire  [WORD_LENGTH-1:0]   MDR,
    output logic                     mem,
    output logic                     rw,
    output logic                     en,
    output logic                     out_valid,
    output logic [WORD_LENGTH-1:0]   out_data,
    output logic [2:0]               out_rdst,
    output logic                     out_wb,
    output logic [ADDRESS_SPACE-1:0] sp,
    output logic                     stack_exc
);

    localparam logic [ADDRESS_SPACE-1:0] SP_INIT = ADDRESS_SPACE'(SP_RESET);
    localparam logic [ADDRESS_SPACE-1:0] SP_ONE  = ADDRESS_SPACE'(1);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_CAPTURE} state_t;

    state_t                   state_reg;
    logic                     mem_reg;
    logic                     rw_reg;
    logic [ADDRESS_SPACE-1:0] mar_reg;
    logic                     mdr_drive_reg;
    logic [WORD_LENGTH-1:0]   mdr_out_reg;
    logic                     push_reg;
    logic                     pop_reg;
    logic [2:0]               rdst_reg;
    logic [ADDRESS_SPACE-1:0] sp_reg;
    logic                     out_valid_reg;
    logic [WORD_LENGTH-1:0]   out_data_reg;
    logic [2:0]               out_rdst_reg;
    logic                     out_wb_reg;
    logic                     stack_exc_reg;

    // Request decode; opcodes 5-7 fall through to PASS.
    logic op_load, op_store, op_push, op_pop, op_pass;
    logic accept;
    logic stack_fault;

    assign op_load  = (in_op == 3'd1);
    assign op_store = (in_op == 3'd2);
    assign op_push  = (in_op == 3'd3);
    assign op_pop   = (in_op == 3'd4);
    assign op_pass  = !(op_load || op_store || op_push || op_pop);
    assign accept   = in_valid && (state_reg == S_IDLE);

`ifdef STACK_BOUNDS_CHECK_EN
    // Full stack (sp at the bottom of memory) or empty stack (sp at its reset value).
    assign stack_fault = (op_push && (sp_reg == '0)) || (op_pop && (sp_reg == SP_INIT));
`else
    assign stack_fault = 1'b0;
`endif

    // Single registered FSM: memory port, stack pointer and result pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= S_IDLE;
            mem_reg       <= 1'b0;
            rw_reg        <= 1'b1;
            mar_reg       <= '0;
            mdr_drive_reg <= 1'b0;
            mdr_out_reg   <= '0;
            push_reg      <= 1'b0;
            pop_reg       <= 1'b0;
            rdst_reg      <= '0;
            sp_reg        <= SP_INIT;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_rdst_reg  <= '0;
            out_wb_reg    <= 1'b0;
            stack_exc_reg <= 1'b0;
        end else begin
            out_valid_reg <= 1'b0;
            stack_exc_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (accept) begin
                        if (op_pass || stack_fault) begin
                            // Immediate result: PASS data, or a suppressed stack op.
                            out_valid_reg <= 1'b1;
                            out_data_reg  <= in_wdata;
                            out_rdst_reg  <= in_rdst;
                            out_wb_reg    <= op_pass ? in_wb : 1'b0;
                            stack_exc_reg <= stack_fault;
                        end else begin
                            state_reg     <= S_ACCESS;
                            mem_reg       <= 1'b1;
                            rw_reg        <= op_load || op_pop;
                            mdr_drive_reg <= op_store || op_push;
                            mdr_out_reg   <= in_wdata;
                            push_reg      <= op_push;
                            pop_reg       <= op_pop;
                            rdst_reg      <= in_rdst;
                            if (op_push)
                                mar_reg <= sp_reg;
                            else if (op_pop)
                                mar_reg <= sp_reg + SP_ONE;
                            else
                                mar_reg <= in_addr;
                        end
                    end
                end
                S_ACCESS: begin
                    mem_reg       <= 1'b0;
                    mdr_drive_reg <= 1'b0;
                    rw_reg        <= 1'b1;
                    if (push_reg)
                        sp_reg <= sp_reg - SP_ONE;
                    else if (pop_reg)
                        sp_reg <= sp_reg + SP_ONE;
                    if (rw_reg) begin
                        // Read data appears on MDR after this edge; grab it next edge.
                        state_reg <= S_CAPTURE;
                    end else begin
                        state_reg     <= S_IDLE;
                        out_valid_reg <= 1'b1;
                        out_wb_reg    <= 1'b0;
                        out_rdst_reg  <= rdst_reg;
                    end
                end
                S_CAPTURE: begin
                    state_reg     <= S_IDLE;
                    out_valid_reg <= 1'b1;
                    out_data_reg  <= MDR;
                    out_wb_reg    <= 1'b1;
                    out_rdst_reg  <= rdst_reg;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_reg == S_IDLE);
    assign MAR       = mar_reg;
    assign MDR       = mdr_drive_reg ? mdr_out_reg : {WORD_LENGTH{1'bz}};
    assign mem       = mem_reg;
    assign en        = mem_reg;
    assign rw        = rw_reg;
    assign sp        = sp_reg;
    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_rdst  = out_rdst_reg;
    assign out_wb    = out_wb_reg;
    assign stack_exc = stack_exc_reg;

endmodule
